a2d_spi_resp: RTL

SPI responder for the A2D command/response protocol: a synthesizable stand-in for the off-chip 8-channel 12-bit converter, used in full-chip simulation and in FPGA loopback. It receives 16-bit command frames from the A2D SPI initiator and decodes the channel. It samples that channel's value from a packed input bus, then returns the held 12-bit result in the next frame. All SPI pins are oversampled on clk; there is no SCLK clock domain.

---
 rtl/a2d_spi_resp.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/a2d_spi_resp.sv
// SPI responder standing in for the off-chip 8-channel 12-bit A2D converter.
// All SPI pins are oversampled on clk. A valid command latches its channel, and the next frame returns that value.
module a2d_spi_resp #(
    parameter int          FRAME_BITS = 16,
    parameter logic [15:0] IDLE_RESP  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [95:0] ch_vals,
    output logic [15:0] rx_cmd,
    output logic        cmd_rdy,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  settle_q, settle_d;
    logic [15:0] rx_shft_q, rx_shft_d;
    logic [15:0] tx_shft_q, tx_shft_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] rx_cmd_q, rx_cmd_d;
    logic [11:0] hold_q, hold_d;
    logic        held_q, held_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        frame_err_q, frame_err_d;
    logic [6:0]  ch_lsb;
    logic [15:0] resp_word;

    logic ss_ff1_q, ss_ff2_q, ss_ff3_q;
    logic sclk_ff1_q, sclk_ff2_q, sclk_ff3_q;
    logic mosi_ff1_q, mosi_ff2_q, mosi_ff3_q;
    logic ss_fall, ss_rise, sclk_rise, sclk_fall;

    // Two metastability flops per pin; the third stage is the edge-detect reference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {ss_ff1_q, ss_ff2_q, ss_ff3_q}       <= 3'b111;
            {sclk_ff1_q, sclk_ff2_q, sclk_ff3_q} <= 3'b000;
            {mosi_ff1_q, mosi_ff2_q, mosi_ff3_q} <= 3'b000;
        end else begin
            // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
            {ss_ff1_q, ss_ff2_q, ss_ff3_q}       <= {SS_n, ss_ff1_q, ss_ff2_q};
            {sclk_ff1_q, sclk_ff2_q, sclk_ff3_q} <= {SCLK, sclk_ff1_q, sclk_ff2_q};
            {mosi_ff1_q, mosi_ff2_q, mosi_ff3_q} <= {MOSI, mosi_ff1_q, mosi_ff2_q};
        end
    end

    assign ss_fall   = ~ss_ff2_q & ss_ff3_q;
    assign ss_rise   = ss_ff2_q & ~ss_ff3_q;
    assign sclk_rise = sclk_ff2_q & ~sclk_ff3_q;
    assign sclk_fall = ~sclk_ff2_q & sclk_ff3_q;

    assign resp_word = held_q ? {4'h0, hold_q} : IDLE_RESP;

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_d     = state_q;
        settle_d    = settle_q;
        rx_shft_d   = rx_shft_q;
        tx_shft_d   = tx_shft_q;
        bit_cnt_d   = bit_cnt_q;
        rx_cmd_d    = rx_cmd_q;
        hold_d      = hold_q;
        held_d      = held_q;
        cmd_rdy_d   = 1'b0;
        frame_err_d = 1'b0;
        ch_lsb      = 7'd0;

        case (state_q)
            // The synchronizer only holds real pin values once two flops have refilled after reset.
            WAIT_HIGH: begin
                if (settle_q != 2'd3) settle_d = settle_q + 2'd1;
                if (settle_q >= 2'd2 && ss_ff2_q) state_d = IDLE;
            end
            IDLE: begin
                if (ss_fall) begin
                    tx_shft_d = resp_word;
                    bit_cnt_d = 5'd0;
                    state_d   = ACTIVE;
                end
            end
            ACTIVE: begin
                if (sclk_rise) begin
                    rx_shft_d = {rx_shft_q[14:0], mosi_ff3_q};
                    if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
                end
                if (sclk_fall) tx_shft_d = {tx_shft_q[14:0], 1'b0};
                // Evaluate with the post-edge count/shift so a coincident last rise is included.
                if (ss_rise) begin
                    state_d = IDLE;
                    if (bit_cnt_d == 5'(FRAME_BITS) && rx_shft_d[15:14] == 2'b00) begin
                        ch_lsb    = {1'b0, rx_shft_d[13:11], 3'b000} + {2'b00, rx_shft_d[13:11], 2'b00};
                        rx_cmd_d  = rx_shft_d;
                        hold_d    = ch_vals[ch_lsb +: 12];
                        held_d    = 1'b1;
                        cmd_rdy_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = WAIT_HIGH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_HIGH;
            settle_q    <= 2'd0;
            rx_shft_q   <= 16'h0000;
            tx_shft_q   <= 16'h0000;
            bit_cnt_q   <= 5'd0;
            rx_cmd_q    <= 16'h0000;
            hold_q      <= 12'h000;
            held_q      <= 1'b0;
            cmd_rdy_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            rx_shft_q   <= rx_shft_d;
            tx_shft_q   <= tx_shft_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_cmd_q    <= rx_cmd_d;
            hold_q      <= hold_d;
            held_q      <= held_d;
            cmd_rdy_q   <= cmd_rdy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign MISO      = (state_q == ACTIVE) ? tx_shft_q[15] : 1'b0;
    assign rx_cmd    = rx_cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign frame_err = frame_err_q;

endmodule
